// File: rtl/ray_pkg.sv
// ray_pkg: shared types for the ray pipeline back end.
// Contents: collector state encoding, index/colour width defaults,
// and the per-pixel result record returned by the cores.
package ray_pkg;

   localparam int IDX_W_DEF   = 32;
   localparam int COLOR_W_DEF = 24;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DRAIN,
      ST_DONE
   } collector_state_t;

   typedef struct packed {
      logic [IDX_W_DEF-1:0]   index;
      logic [COLOR_W_DEF-1:0] color;
   } pixel_result_t;

endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO buffering pixel results.
// Ports: clk, reset_n (sync, active-low), push/din, pop/dout (head),
// full, empty, count. Push when full and pop when empty are ignored.
module result_fifo #(
   parameter int WIDTH = 45,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible while count > 0.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/pixel_collector.sv
// pixel_collector: round-robin gathers core ray results, buffers them in a
// FIFO and writes them to the framebuffer; counts pixels, pulses frame_done.
// Ports: clk, reset_n (sync, active-low), start, image_width/height,
// core_valid/ready/index/color, fb_wr_en/ready/addr/data, pixel_count,
// busy, frame_done, range_err. Macro PIXEL_CHECKSUM_EN adds frame_checksum.
module pixel_collector
   import ray_pkg::*;
#(
   parameter int NUM_CORES  = 4,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int COLOR_W    = COLOR_W_DEF,
   parameter int ADDR_W     = 21,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic [12:0]                  image_width,
   input  logic [12:0]                  image_height,
   input  logic [NUM_CORES-1:0]         core_valid,
   output logic [NUM_CORES-1:0]         core_ready,
   input  logic [NUM_CORES*IDX_W-1:0]   core_index,
   input  logic [NUM_CORES*COLOR_W-1:0] core_color,
   output logic                         fb_wr_en,
   input  logic                         fb_wr_ready,
   output logic [ADDR_W-1:0]            fb_wr_addr,
   output logic [COLOR_W-1:0]           fb_wr_data,
   output logic [IDX_W-1:0]             pixel_count,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         range_err
`ifdef PIXEL_CHECKSUM_EN
   ,
   output logic [31:0]                  frame_checksum
`endif
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int FW = ADDR_W + COLOR_W;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   collector_state_t state;
   collector_state_t state_nx;

   logic [IDX_W-1:0]   total;
   logic [IDX_W-1:0]   accepted;
   logic [25:0]        area;
   logic [IDX_W-1:0]   area_t;
   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      grant;
   logic               grant_vld;
   logic [IDX_W-1:0]   g_index;
   logic [COLOR_W-1:0] g_color;
   logic               collect_open;
   logic               hs;
   logic               in_range;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FW-1:0]      fifo_dout;
   logic [CW-1:0]      fifo_count;

   assign area   = image_width * image_height;
   assign area_t = IDX_W'(area);

   // First valid core at or after rr_ptr, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (!grant_vld && core_valid[(int'(rr_ptr) + k) % NUM_CORES]) begin
            grant_vld = 1'b1;
            grant     = PW'((int'(rr_ptr) + k) % NUM_CORES);
         end
      end
   end

   assign g_index = core_index[int'(grant)*IDX_W +: IDX_W];
   assign g_color = core_color[int'(grant)*COLOR_W +: COLOR_W];

   // Stop granting once every expected pixel has been accepted.
   assign collect_open = (state == ST_COLLECT) && (accepted != total)
                         && !fifo_full;
   assign hs           = collect_open && grant_vld;
   assign core_ready   = hs ? (NUM_CORES'(1) << grant) : '0;
   assign in_range     = (g_index < total);
   assign push         = hs && in_range;

   assign fb_wr_en   = !fifo_empty
                       && (state == ST_COLLECT || state == ST_DRAIN);
   assign pop        = fb_wr_en && fb_wr_ready;
   assign fb_wr_addr = fb_wr_en ? fifo_dout[FW-1 -: ADDR_W] : '0;
   assign fb_wr_data = fb_wr_en ? fifo_dout[COLOR_W-1:0] : '0;

   assign busy       = (state == ST_COLLECT) || (state == ST_DRAIN);
   assign frame_done = (state == ST_DONE);

   result_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     ({g_index[ADDR_W-1:0], g_color}),
      .pop     (pop),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (start) state_nx = (area_t == '0) ? ST_DONE : ST_COLLECT;
         end
         ST_COLLECT: begin
            if (accepted == total) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (fifo_count == '0 && pixel_count == total)
               state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         total       <= '0;
         accepted    <= '0;
         pixel_count <= '0;
         range_err   <= 1'b0;
         rr_ptr      <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && start) begin
            total       <= area_t;
            accepted    <= '0;
            pixel_count <= '0;
            range_err   <= 1'b0;
         end
         if (hs) begin
            rr_ptr <= (int'(grant) == NUM_CORES - 1) ? '0 : grant + 1'b1;
            if (in_range) accepted <= accepted + 1'b1;
            else range_err <= 1'b1;
         end
         if (pop) pixel_count <= pixel_count + 1'b1;
      end
   end

`ifdef PIXEL_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_checksum <= '0;
      end else if (state == ST_IDLE && start) begin
         frame_checksum <= '0;
      end else if (pop) begin
         frame_checksum <= {frame_checksum[30:0], frame_checksum[31]}
                           ^ 32'(fb_wr_data);
      end
   end
`endif

endmodule

// File: doc/pixel_collector.md
Name: pixel_collector

Overview:
- Receiving end of the per-core ray pipelines. Each core finishes a ray and returns a pixel index (the loop index it was issued) plus a shaded colour.
- The block arbitrates round-robin between cores, buffers results in a small FIFO and writes them into the framebuffer.
- It counts completed pixels and signals frame completion to the top-level controller, which then re-enables the ray generators.

Parameters:
- NUM_CORES, 4, number of core result ports (1..8).
- IDX_W, 32, pixel index width (matches the loop index width).
- COLOR_W, 24, colour width (RGB888).
- ADDR_W, 21, framebuffer address width.
- FIFO_DEPTH, 8, result FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins frame collection.
- image_width  in  13  pixels per row; latched on start.
- image_height  in  13  rows; latched on start.
- core_valid  in  NUM_CORES  per-core result valid.
- core_ready  out  NUM_CORES  per-core accept; at most one bit high per cycle.
- core_index  in  NUM_CORES*IDX_W  packed pixel indices; core i at [i*IDX_W +: IDX_W].
- core_color  in  NUM_CORES*COLOR_W  packed colours.
- fb_wr_en  out  1  framebuffer write request.
- fb_wr_ready  in  1  framebuffer accepts the write this cycle.
- fb_wr_addr  out  ADDR_W  pixel address, equal to index[ADDR_W-1:0].
- fb_wr_data  out  COLOR_W  colour.
- pixel_count  out  IDX_W  pixels written this frame.
- busy  out  1  high in COLLECT and DRAIN.
- frame_done  out  1  one-cycle pulse when the frame is complete.
- range_err  out  1  sticky; an out-of-range index was received.

Behaviour:
- Reset values: all outputs 0. State IDLE. FIFO empty. Round-robin pointer at core 0.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - On start, latch total = image_width*image_height as an IDX_W-wide value.
  - Clear pixel_count, the accepted counter and range_err.
  - Go to DONE if total==0, otherwise go to COLLECT.
  - start outside IDLE is ignored.
- COLLECT, arbitration:
  - Each cycle, if the FIFO is not full, grant the first valid core at or after rr_ptr (wrapping).
  - core_ready[grant]=1; all other ready bits are 0.
  - On a handshake, rr_ptr <= grant+1 mod NUM_CORES.
  - FIFO full: all ready bits 0.
- COLLECT, accepted results:
  - Index < total: push {index, color} to the FIFO and increment the accepted counter.
  - Index >= total: ready is still given, nothing is pushed, range_err is set and the counter is not incremented.
- Move to DRAIN the cycle after the accepted counter reaches total. No ready is asserted in DRAIN.
- Write port:
  - fb_wr_en = FIFO not empty, in COLLECT or DRAIN. Addr and data come from the FIFO head.
  - Pop and increment pixel_count when fb_wr_en && fb_wr_ready.
  - Addr and data are held stable while fb_wr_ready is low.
- DRAIN goes to DONE when the FIFO is empty and pixel_count==total.
- DONE asserts frame_done for exactly one cycle, then returns to IDLE. pixel_count holds until the next start.
- Latency: handshake in cycle N gives fb_wr_en no earlier than N+1 (registered FIFO output).
- Simultaneous push and pop: allowed when the FIFO is not full; occupancy is unchanged.
- Full/empty: no push when full, no write when empty.
- Duplicate indices are written again and count twice. Order across cores is not preserved.
- Reset mid-frame: immediate return to reset values; any FIFO contents are discarded.

Optional Feature:
- Macro PIXEL_CHECKSUM_EN.
- When defined:
  - Adds output frame_checksum [31:0], cleared on start.
  - On each framebuffer write: checksum <= {checksum[30:0], checksum[31]} ^ {{(32-COLOR_W){1'b0}}, fb_wr_data}.
  - The value is valid when frame_done is high.
- When undefined: the port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package ray_pkg holds:
  - collector state enum (IDLE, COLLECT, DRAIN, DONE).
  - IDX_W and COLOR_W defaults.
  - a pixel_result_t struct {index, color}.
- Natural sub-module: result_fifo. It is a parameterised synchronous FIFO with push, pop, full, empty and count, instantiated once.

Test Plan:
- 4x2 image, cores 0..3 each return indices i, i+4 with colour=index, all valid together.
  -> Grants rotate 0,1,2,3; 8 writes with addr==data.
  -> pixel_count=8; frame_done one cycle after the last write; busy low afterwards.
- fb_wr_ready held 0 for 20 cycles during an 8-pixel frame.
  -> FIFO fills to 8 and all core_ready go 0.
  -> fb_wr_addr/data stay stable.
  -> After release, all 8 pixels are written in 8 cycles.
- Core 2 sends index 100 on a 4x4 image.
  -> Accepted with no write, range_err=1.
  -> The frame completes only after 16 valid pixels.
- start with image_width=0.
  -> DONE next cycle, then frame_done pulse; no core_ready and no writes.
- reset_n low for 1 cycle with 3 entries in the FIFO mid-frame.
  -> Next cycle: fb_wr_en=0, pixel_count=0, state IDLE.
- PIXEL_CHECKSUM_EN with a 2-pixel frame, colours 0x000001 then 0x000002.
  -> frame_checksum=0x00000000, since rotl(0x1)=0x2, xor 0x2 = 0x0.
